// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator job controller.
package cnn_layer_accel_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PARAM     = 3'd1,
        FETCH_REQ = 3'd2,
        FETCH     = 3'd3,
        EXEC      = 3'd4,
        COMPLETE  = 3'd5
    } state_e;

    localparam logic [31:0] DBG_ADDR_STATE     = 32'd0;
    localparam logic [31:0] DBG_ADDR_JOB_CNT   = 32'd1;
    localparam logic [31:0] DBG_ADDR_BEAT_CNT  = 32'd2;
    localparam logic [31:0] DBG_ADDR_PARAMS_LO = 32'd3;
    localparam logic [31:0] DBG_DEFAULT_DATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/cnn_layer_accel_dbg_rd.sv
// Debug read port: one registered read per cycle, data and ack one cycle after the request.
module cnn_layer_accel_dbg_rd
    import cnn_layer_accel_pkg::*;
#(
    parameter int C_DBG_ADDR_WIDTH = 4
) (
    input  logic                        clk_if,
    input  logic                        rst,
    input  logic [C_DBG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                        rd_addr_valid_i,
    input  state_e                      state_i,
    input  logic [31:0]                 job_cnt_i,
    input  logic [15:0]                 cfg_beat_cnt_i,
    input  logic [31:0]                 job_params_lo_i,
    output logic                        rd_ack_o,
    output logic [31:0]                 rd_data_o
);

    logic [31:0] rd_data_d;
    logic [31:0] rd_data_q;
    logic        rd_ack_q;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        rd_data_d = DBG_DEFAULT_DATA;
        case (32'(rd_addr_i))
            DBG_ADDR_STATE:     rd_data_d = {29'b0, state_i};
            DBG_ADDR_JOB_CNT:   rd_data_d = job_cnt_i;
            DBG_ADDR_BEAT_CNT:  rd_data_d = {16'b0, cfg_beat_cnt_i};
            DBG_ADDR_PARAMS_LO: rd_data_d = job_params_lo_i;
            default:            rd_data_d = DBG_DEFAULT_DATA;
        endcase
    end

    always_ff @(posedge clk_if) begin
        if (rst) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q  <= rd_addr_valid_i;
            rd_data_q <= rd_addr_valid_i ? rd_data_d : '0;
        end
    end

    assign rd_ack_o  = rd_ack_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Job controller: host handshake, descriptor latch, config-beat forwarding, core start/done sequencing.
module cnn_layer_accel_job_ctrl
    import cnn_layer_accel_pkg::*;
#(
    parameter int C_DBG_ADDR_WIDTH = 4,
    parameter int C_NUM_CFG_LANES  = 4
) (
    input  logic                        clk_if,
    input  logic                        rst,
    input  logic                        job_start,
    output logic                        job_accept,
    input  logic [127:0]                job_parameters,
    input  logic                        job_parameters_valid,
    output logic                        job_fetch_request,
    input  logic                        job_fetch_ack,
    input  logic                        job_fetch_complete,
    output logic                        job_complete,
    input  logic                        job_complete_ack,
    input  logic [C_NUM_CFG_LANES-1:0]  config_valid,
    output logic [C_NUM_CFG_LANES-1:0]  config_accept,
    input  logic [127:0]                config_data,
    output logic [C_NUM_CFG_LANES-1:0]  cfg_wr_en,
    output logic [127:0]                cfg_wr_data,
    output logic [127:0]                job_params,
    output logic                        exec_start,
    input  logic                        exec_done,
    input  logic [C_DBG_ADDR_WIDTH-1:0] slv_dbg_rdAddr,
    input  logic                        slv_dbg_rdAddr_valid,
    output logic                        slv_dbg_rdAck,
    output logic [31:0]                 slv_dbg_data
);

    state_e                     state_q, state_d;
    logic                       job_accept_q;
    logic                       exec_start_q;
    logic [C_NUM_CFG_LANES-1:0] cfg_wr_en_q;
    logic [127:0]               cfg_wr_data_q;
    logic [127:0]               job_params_q;
    logic [15:0]                beat_cnt_q, beat_cnt_d;
    logic [31:0]                job_cnt_q, job_cnt_d;
    logic [C_NUM_CFG_LANES-1:0] lowest_valid;
    logic                       beat_accepted;

    // x & -x isolates the lowest set bit, giving lowest-lane-wins arbitration.
    assign lowest_valid  = config_valid & (~config_valid + C_NUM_CFG_LANES'(1));
    assign config_accept = (!rst && state_q == FETCH) ? lowest_valid : '0;
    assign beat_accepted = |config_accept;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        job_cnt_d  = job_cnt_q;
        case (state_q)
            IDLE:      if (job_start) state_d = PARAM;
            PARAM:     if (job_parameters_valid) state_d = FETCH_REQ;
            FETCH_REQ: if (job_fetch_ack) begin
                state_d    = FETCH;
                beat_cnt_d = '0;
            end
            FETCH:     if (job_fetch_complete) state_d = EXEC;
            EXEC:      if (exec_done) state_d = COMPLETE;
            COMPLETE:  if (job_complete_ack) begin
                state_d   = IDLE;
                job_cnt_d = job_cnt_q + 32'd1;
            end
            default:   state_d = IDLE;
        endcase
        if (beat_accepted) beat_cnt_d = beat_cnt_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            state_q       <= IDLE;
            job_accept_q  <= 1'b0;
            exec_start_q  <= 1'b0;
            cfg_wr_en_q   <= '0;
            cfg_wr_data_q <= '0;
            job_params_q  <= '0;
            beat_cnt_q    <= '0;
            job_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            job_cnt_q    <= job_cnt_d;
            job_accept_q <= (state_q == IDLE) && job_start;
            exec_start_q <= (state_q == FETCH) && job_fetch_complete;
            cfg_wr_en_q  <= config_accept;
            if (beat_accepted) cfg_wr_data_q <= config_data;
            if (state_q == PARAM && job_parameters_valid) job_params_q <= job_parameters;
        end
    end

    assign job_accept        = job_accept_q;
    assign exec_start        = exec_start_q;
    assign cfg_wr_en         = cfg_wr_en_q;
    assign cfg_wr_data       = cfg_wr_data_q;
    assign job_params        = job_params_q;
    assign job_fetch_request = !rst && (state_q == FETCH_REQ);
    assign job_complete      = !rst && (state_q == COMPLETE);

    cnn_layer_accel_dbg_rd #(
        .C_DBG_ADDR_WIDTH (C_DBG_ADDR_WIDTH)
    ) u_dbg_rd (
        .clk_if          (clk_if),
        .rst             (rst),
        .rd_addr_i       (slv_dbg_rdAddr),
        .rd_addr_valid_i (slv_dbg_rdAddr_valid),
        .state_i         (state_q),
        .job_cnt_i       (job_cnt_q),
        .cfg_beat_cnt_i  (beat_cnt_q),
        .job_params_lo_i (job_params_q[31:0]),
        .rd_ack_o        (slv_dbg_rdAck),
        .rd_data_o       (slv_dbg_data)
    );

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Directed self-checking bench for cnn_layer_accel_job_ctrl.
module tb_cnn_layer_accel_job_ctrl;

    logic         clk_if = 1'b0;
    logic         rst;
    logic         job_start;
    logic         job_accept;
    logic [127:0] job_parameters;
    logic         job_parameters_valid;
    logic         job_fetch_request;
    logic         job_fetch_ack;
    logic         job_fetch_complete;
    logic         job_complete;
    logic         job_complete_ack;
    logic [3:0]   config_valid;
    logic [3:0]   config_accept;
    logic [127:0] config_data;
    logic [3:0]   cfg_wr_en;
    logic [127:0] cfg_wr_data;
    logic [127:0] job_params;
    logic         exec_start;
    logic         exec_done;
    logic [3:0]   slv_dbg_rdAddr;
    logic         slv_dbg_rdAddr_valid;
    logic         slv_dbg_rdAck;
    logic [31:0]  slv_dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    int acc_cnt = 0;
    int es_cnt  = 0;
    int wr2_cnt = 0;
    int jc_cnt  = 0;

    localparam logic [127:0] P1 = 128'h1111_2222_3333_4444_5555_6666_7777_00A5;
    localparam logic [127:0] P2 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1234_5678;
    localparam logic [127:0] P3 = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_CAFE_F00D;

    always #5 clk_if = ~clk_if;

    cnn_layer_accel_job_ctrl #(
        .C_DBG_ADDR_WIDTH (4),
        .C_NUM_CFG_LANES  (4)
    ) dut (
        .clk_if               (clk_if),
        .rst                  (rst),
        .job_start            (job_start),
        .job_accept           (job_accept),
        .job_parameters       (job_parameters),
        .job_parameters_valid (job_parameters_valid),
        .job_fetch_request    (job_fetch_request),
        .job_fetch_ack        (job_fetch_ack),
        .job_fetch_complete   (job_fetch_complete),
        .job_complete         (job_complete),
        .job_complete_ack     (job_complete_ack),
        .config_valid         (config_valid),
        .config_accept        (config_accept),
        .config_data          (config_data),
        .cfg_wr_en            (cfg_wr_en),
        .cfg_wr_data          (cfg_wr_data),
        .job_params           (job_params),
        .exec_start           (exec_start),
        .exec_done            (exec_done),
        .slv_dbg_rdAddr       (slv_dbg_rdAddr),
        .slv_dbg_rdAddr_valid (slv_dbg_rdAddr_valid),
        .slv_dbg_rdAck        (slv_dbg_rdAck),
        .slv_dbg_data         (slv_dbg_data)
    );

    // Pulse/cycle counters sampled mid-cycle.
    always @(negedge clk_if) begin
        if (job_accept) acc_cnt++;
        if (exec_start) es_cnt++;
        if (cfg_wr_en == 4'b0100) wr2_cnt++;
        if (job_complete) jc_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_if);
        #1;
    endtask

    task automatic dbg_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        slv_dbg_rdAddr       = addr;
        slv_dbg_rdAddr_valid = 1'b1;
        step();
        slv_dbg_rdAddr_valid = 1'b0;
        check({tag, "_ack"}, 128'(slv_dbg_rdAck), 128'(1));
        check(tag, 128'(slv_dbg_data), 128'(exp));
    endtask

    // Drives IDLE -> PARAM -> FETCH_REQ and leaves the FSM waiting for the fetch ack.
    task automatic start_job(input logic [127:0] p);
        job_start = 1'b1;
        step();
        job_start = 1'b0;
        check("job_accept_pulse", 128'(job_accept), 128'(1));
        step();
        check("job_accept_drop", 128'(job_accept), 128'(0));
        job_parameters       = p;
        job_parameters_valid = 1'b1;
        step();
        job_parameters_valid = 1'b0;
        check("fetch_req_up", 128'(job_fetch_request), 128'(1));
        check("job_params_latch", job_params, p);
    endtask

    initial begin
        int acc0, es0, wr0, jc0;
        rst                  = 1'b1;
        job_start            = 1'b0;
        job_parameters       = '0;
        job_parameters_valid = 1'b0;
        job_fetch_ack        = 1'b0;
        job_fetch_complete   = 1'b0;
        job_complete_ack     = 1'b0;
        config_valid         = '0;
        config_data          = '0;
        exec_done            = 1'b0;
        slv_dbg_rdAddr       = '0;
        slv_dbg_rdAddr_valid = 1'b0;

        step();
        step();
        check("rst_job_accept", 128'(job_accept), 128'(0));
        check("rst_fetch_req", 128'(job_fetch_request), 128'(0));
        check("rst_job_complete", 128'(job_complete), 128'(0));
        check("rst_cfg_accept", 128'(config_accept), 128'(0));
        check("rst_cfg_wr_en", 128'(cfg_wr_en), 128'(0));
        check("rst_cfg_wr_data", cfg_wr_data, 128'(0));
        check("rst_exec_start", 128'(exec_start), 128'(0));
        check("rst_dbg_ack", 128'(slv_dbg_rdAck), 128'(0));
        check("rst_dbg_data", 128'(slv_dbg_data), 128'(0));
        rst = 1'b0;
        step();
        dbg_read(4'd0, 32'd0, "rst_state");
        dbg_read(4'd1, 32'd0, "rst_job_cnt");
        dbg_read(4'd2, 32'd0, "rst_beat_cnt");

        // Full job: ack after 3 cycles, 5 beats on lane 2, exec_done after 10 cycles.
        acc0 = acc_cnt; es0 = es_cnt; wr0 = wr2_cnt;
        start_job(P1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fetch_req_hold", 128'(job_fetch_request), 128'(1));
        end
        job_fetch_ack = 1'b1;
        step();
        job_fetch_ack = 1'b0;
        check("fetch_req_drop", 128'(job_fetch_request), 128'(0));
        for (int i = 0; i < 5; i++) begin
            config_valid = 4'b0100;
            config_data  = 128'h100 + 128'(i);
            #1;
            check("lane2_accept", 128'(config_accept), 128'(4'b0100));
            step();
            check("lane2_wr_en", 128'(cfg_wr_en), 128'(4'b0100));
            check("lane2_wr_data", cfg_wr_data, 128'h100 + 128'(i));
        end
        config_valid       = '0;
        job_fetch_complete = 1'b1;
        step();
        job_fetch_complete = 1'b0;
        check("exec_start_pulse", 128'(exec_start), 128'(1));
        check("wr_en_idle_after_fetch", 128'(cfg_wr_en), 128'(0));
        repeat (9) step();
        check("no_complete_in_exec", 128'(job_complete), 128'(0));
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check("job_complete_up", 128'(job_complete), 128'(1));
        step();
        step();
        check("job_complete_hold", 128'(job_complete), 128'(1));
        job_complete_ack = 1'b1;
        step();
        job_complete_ack = 1'b0;
        check("job_complete_drop", 128'(job_complete), 128'(0));
        check("accept_pulses", 128'(acc_cnt - acc0), 128'(1));
        check("exec_start_pulses", 128'(es_cnt - es0), 128'(1));
        check("lane2_writes", 128'(wr2_cnt - wr0), 128'(5));
        dbg_read(4'd1, 32'd1, "job1_job_cnt");
        dbg_read(4'd2, 32'd5, "job1_beat_cnt");
        dbg_read(4'd3, 32'h7777_00A5, "job1_params_lo");

        // Two lanes valid: lowest wins; then a beat together with fetch_complete.
        start_job(P2);
        job_fetch_ack = 1'b1;
        step();
        job_fetch_ack = 1'b0;
        config_valid  = 4'b1010;
        config_data   = 128'h55;
        #1;
        check("prio_accept_c1", 128'(config_accept), 128'(4'b0010));
        step();
        check("prio_wr_en_c1", 128'(cfg_wr_en), 128'(4'b0010));
        check("prio_accept_c2", 128'(config_accept), 128'(4'b0010));
        step();
        config_valid = '0;
        check("prio_wr_en_c2", 128'(cfg_wr_en), 128'(4'b0010));
        dbg_read(4'd2, 32'd2, "prio_beat_cnt");
        config_valid       = 4'b0001;
        config_data        = 128'h77;
        job_fetch_complete = 1'b1;
        #1;
        check("last_beat_accept", 128'(config_accept), 128'(4'b0001));
        step();
        config_valid       = '0;
        job_fetch_complete = 1'b0;
        check("last_beat_wr_en", 128'(cfg_wr_en), 128'(4'b0001));
        check("last_beat_wr_data", cfg_wr_data, 128'h77);
        check("last_beat_exec_start", 128'(exec_start), 128'(1));
        dbg_read(4'd0, 32'd4, "last_beat_state");
        dbg_read(4'd2, 32'd3, "last_beat_cnt");

        // Reset in EXEC aborts the job.
        jc0 = jc_cnt;
        rst = 1'b1;
        step();
        check("midrst_complete", 128'(job_complete), 128'(0));
        check("midrst_wr_data", cfg_wr_data, 128'(0));
        rst       = 1'b0;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        dbg_read(4'd0, 32'd0, "midrst_state");
        dbg_read(4'd1, 32'd0, "midrst_job_cnt");
        dbg_read(4'd3, 32'd0, "midrst_params");
        check("midrst_no_complete", 128'(jc_cnt - jc0), 128'(0));

        // job_start in FETCH_REQ is ignored; the job then completes normally.
        acc0 = acc_cnt;
        start_job(P3);
        job_start = 1'b1;
        step();
        job_start = 1'b0;
        check("fetchreq_start_ignored", 128'(job_accept), 128'(0));
        dbg_read(4'd0, 32'd2, "fetchreq_state");
        check("fetchreq_accept_cnt", 128'(acc_cnt - acc0), 128'(1));
        job_fetch_ack = 1'b1;
        step();
        job_fetch_ack = 1'b0;
        config_valid  = 4'b1000;
        config_data   = 128'h99;
        step();
        config_valid       = '0;
        check("job3_wr_en", 128'(cfg_wr_en), 128'(4'b1000));
        job_fetch_complete = 1'b1;
        step();
        job_fetch_complete = 1'b0;
        exec_done          = 1'b1;
        step();
        exec_done = 1'b0;
        check("job3_complete", 128'(job_complete), 128'(1));
        job_complete_ack = 1'b1;
        step();
        job_complete_ack = 1'b0;
        dbg_read(4'd1, 32'd1, "job3_job_cnt");

        // Back-to-back debug reads.
        slv_dbg_rdAddr       = 4'd3;
        slv_dbg_rdAddr_valid = 1'b1;
        step();
        check("b2b_ack0", 128'(slv_dbg_rdAck), 128'(1));
        check("b2b_data0", 128'(slv_dbg_data), 128'(32'hCAFE_F00D));
        slv_dbg_rdAddr = 4'd7;
        step();
        check("b2b_ack1", 128'(slv_dbg_rdAck), 128'(1));
        check("b2b_data1", 128'(slv_dbg_data), 128'(32'hDEAD_BEEF));
        slv_dbg_rdAddr = 4'd0;
        step();
        check("b2b_ack2", 128'(slv_dbg_rdAck), 128'(1));
        check("b2b_data2", 128'(slv_dbg_data), 128'(0));
        slv_dbg_rdAddr_valid = 1'b0;
        step();
        check("b2b_ack_drop", 128'(slv_dbg_rdAck), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
